// File: rtl/pcie_dl_tx_scheduler.sv
// PCIe data link layer transmit scheduler.
// Merges TLPs with Ack/Nak and UpdateFC DLLPs onto one registered stream.
module pcie_dl_tx_scheduler #(
   parameter int DATA_WIDTH      = 32,
   parameter int KEEP_WIDTH      = DATA_WIDTH/8,
   parameter int USER_WIDTH      = 3,
   parameter int TIMER_WIDTH     = 16,
   parameter int ACK_LATENCY     = 255,
   parameter int UPDATEFC_PERIOD = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  link_active_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep,
   input  logic                  s_axis_tlp_tvalid,
   input  logic                  s_axis_tlp_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser,
   output logic                  s_axis_tlp_tready,
   output logic [DATA_WIDTH-1:0] m_axis_phy_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_phy_tkeep,
   output logic                  m_axis_phy_tvalid,
   output logic                  m_axis_phy_tlast,
   output logic [USER_WIDTH-1:0] m_axis_phy_tuser,
   input  logic                  m_axis_phy_tready,
   input  logic                  ack_req_i,
   input  logic                  ack_nak_i,
   input  logic [11:0]           ack_seq_i,
   input  logic [2:0]            fc_update_req_i,
   input  logic [7:0]            fc_ph_i,
   input  logic [7:0]            fc_nph_i,
   input  logic [7:0]            fc_cplh_i,
   input  logic [11:0]           fc_pd_i,
   input  logic [11:0]           fc_npd_i,
   input  logic [11:0]           fc_cpld_i,
   output logic                  ack_pending_o,
   output logic                  dllp_sent_o
);

   generate
      if (DATA_WIDTH != 32 || USER_WIDTH < 3) begin : g_bad_cfg
         $error("pcie_dl_tx_scheduler: only 32-bit data, >=3-bit tuser");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_TLP, ST_DLLP} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_ACK, SEL_FC, SEL_TLP} sel_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   sel_t                   w_sel;
   logic                   r_tvalid;
   logic [DATA_WIDTH-1:0]  r_tdata;
   logic [KEEP_WIDTH-1:0]  r_tkeep;
   logic                   r_tlast;
   logic [USER_WIDTH-1:0]  r_tuser;
   logic                   r_ack_pend;
   logic                   r_nak_pend;
   logic [11:0]            r_ack_seq;
   logic [TIMER_WIDTH-1:0] r_ack_tmr;
   logic [2:0]             r_fc_pend;
   logic [TIMER_WIDTH-1:0] r_fc_tmr;

   logic                   w_load;
   logic                   w_urgent;
   logic                   w_fc_wrap;
   logic                   w_tlp_rdy;
   logic                   w_ack_sent;
   logic [1:0]             w_fc_idx;
   logic [2:0]             w_fc_clr;
   logic [7:0]             w_fc_hdr;
   logic [11:0]            w_fc_dat;
   logic [31:0]            w_ack_data;
   logic [31:0]            w_fc_data;

   assign w_load    = !r_tvalid || m_axis_phy_tready;
   assign w_urgent  = r_ack_tmr >= TIMER_WIDTH'(ACK_LATENCY);
   assign w_fc_wrap = link_active_i &&
                      (r_fc_tmr == TIMER_WIDTH'(UPDATEFC_PERIOD-1));

   always_comb begin
      w_fc_idx = 2'd2;
      w_fc_hdr = fc_cplh_i;
      w_fc_dat = fc_cpld_i;
      if (r_fc_pend[0]) begin
         w_fc_idx = 2'd0;
         w_fc_hdr = fc_ph_i;
         w_fc_dat = fc_pd_i;
      end else if (r_fc_pend[1]) begin
         w_fc_idx = 2'd1;
         w_fc_hdr = fc_nph_i;
         w_fc_dat = fc_npd_i;
      end
   end

   // Byte 0 sits in tdata[7:0]; a pending Nak absorbs any pending Ack.
   assign w_ack_data = {r_ack_seq[7:0], 4'h0, r_ack_seq[11:8], 8'h00,
                        r_nak_pend ? 8'h10 : 8'h00};
   assign w_fc_data  = {w_fc_dat[7:0], w_fc_hdr[1:0], 2'b00,
                        w_fc_dat[11:8], 2'b00, w_fc_hdr[7:2],
                        2'b10, w_fc_idx, 4'h0};

   always_comb begin
      w_state_nxt = r_state;
      w_sel       = SEL_NONE;
      w_tlp_rdy   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               if (link_active_i &&
                   (r_nak_pend || (r_ack_pend && w_urgent))) begin
                  w_sel       = SEL_ACK;
                  w_state_nxt = ST_DLLP;
               end else if (link_active_i && |r_fc_pend) begin
                  w_sel       = SEL_FC;
                  w_state_nxt = ST_DLLP;
               end else if (s_axis_tlp_tvalid) begin
                  w_state_nxt = ST_TLP;
               end else if (link_active_i && r_ack_pend) begin
                  w_sel       = SEL_ACK;
                  w_state_nxt = ST_DLLP;
               end
            end
         end
         ST_TLP: begin
            w_tlp_rdy = w_load;
            if (w_load && s_axis_tlp_tvalid) begin
               w_sel = SEL_TLP;
               if (s_axis_tlp_tlast) w_state_nxt = ST_IDLE;
            end
         end
         ST_DLLP: begin
            if (m_axis_phy_tready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_ack_sent = (w_sel == SEL_ACK);
   assign w_fc_clr   = (w_sel == SEL_FC) ? (3'b001 << w_fc_idx) : 3'b000;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tuser  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            unique case (w_sel)
               SEL_ACK, SEL_FC: begin
                  r_tvalid <= 1'b1;
                  r_tdata  <= (w_sel == SEL_ACK) ? w_ack_data : w_fc_data;
                  r_tkeep  <= '1;
                  r_tlast  <= 1'b1;
                  r_tuser  <= USER_WIDTH'(1);
               end
               SEL_TLP: begin
                  r_tvalid <= 1'b1;
                  r_tdata  <= s_axis_tlp_tdata;
                  r_tkeep  <= s_axis_tlp_tkeep;
                  r_tlast  <= s_axis_tlp_tlast;
                  r_tuser  <= s_axis_tlp_tuser & ~USER_WIDTH'(1);
               end
               default: r_tvalid <= 1'b0;
            endcase
         end
      end
   end

   // A request arriving on the cycle of a send stays pending.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ack_pend <= 1'b0;
         r_nak_pend <= 1'b0;
         r_ack_seq  <= '0;
         r_ack_tmr  <= '0;
         r_fc_pend  <= '0;
         r_fc_tmr   <= '0;
      end else begin
         r_ack_pend <= ack_req_i | (r_ack_pend & ~w_ack_sent);
         r_nak_pend <= (ack_req_i & ack_nak_i) |
                       (r_nak_pend & ~w_ack_sent);
         if (ack_req_i) r_ack_seq <= ack_seq_i;
         if (!link_active_i || w_ack_sent || !r_ack_pend)
            r_ack_tmr <= '0;
         else if (r_ack_tmr != '1)
            r_ack_tmr <= r_ack_tmr + 1'b1;
         r_fc_pend <= fc_update_req_i | {3{w_fc_wrap}} |
                      (r_fc_pend & ~w_fc_clr);
         if (!link_active_i || w_fc_wrap)
            r_fc_tmr <= '0;
         else
            r_fc_tmr <= r_fc_tmr + 1'b1;
      end
   end

   assign s_axis_tlp_tready = w_tlp_rdy;
   assign m_axis_phy_tvalid = r_tvalid;
   assign m_axis_phy_tdata  = r_tdata;
   assign m_axis_phy_tkeep  = r_tkeep;
   assign m_axis_phy_tlast  = r_tlast;
   assign m_axis_phy_tuser  = r_tuser;
   assign ack_pending_o     = r_ack_pend;
   assign dllp_sent_o       = r_tvalid & m_axis_phy_tready & r_tuser[0];

endmodule

// File: tb/tb_pcie_dl_tx_scheduler.sv
// Directed bench for pcie_dl_tx_scheduler: DLLP encoding table,
// urgent Ack under traffic, Nak override, UpdateFC refresh, stalls, reset.
module tb_pcie_dl_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        link;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tlast;
   logic [2:0]  s_tuser;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tlast;
   logic [2:0]  m_tuser;
   logic        m_tready;
   logic        ack_req;
   logic        ack_nak;
   logic [11:0] ack_seq;
   logic [2:0]  fc_req;
   logic [7:0]  fc_ph, fc_nph, fc_cplh;
   logic [11:0] fc_pd, fc_npd, fc_cpld;
   logic        ack_pend;
   logic        dllp_sent;

   always #5 clk = ~clk;

   pcie_dl_tx_scheduler #(
      .ACK_LATENCY(16),
      .UPDATEFC_PERIOD(64)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .link_active_i(link),
      .s_axis_tlp_tdata(s_tdata), .s_axis_tlp_tkeep(s_tkeep),
      .s_axis_tlp_tvalid(s_tvalid), .s_axis_tlp_tlast(s_tlast),
      .s_axis_tlp_tuser(s_tuser), .s_axis_tlp_tready(s_tready),
      .m_axis_phy_tdata(m_tdata), .m_axis_phy_tkeep(m_tkeep),
      .m_axis_phy_tvalid(m_tvalid), .m_axis_phy_tlast(m_tlast),
      .m_axis_phy_tuser(m_tuser), .m_axis_phy_tready(m_tready),
      .ack_req_i(ack_req), .ack_nak_i(ack_nak), .ack_seq_i(ack_seq),
      .fc_update_req_i(fc_req),
      .fc_ph_i(fc_ph), .fc_nph_i(fc_nph), .fc_cplh_i(fc_cplh),
      .fc_pd_i(fc_pd), .fc_npd_i(fc_npd), .fc_cpld_i(fc_cpld),
      .ack_pending_o(ack_pend), .dllp_sent_o(dllp_sent)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [2:0]  u;
   } beat_t;

   logic [31:0] ad_q[$];
   logic [31:0] fc_q[$];
   int          ad_pos[$];
   beat_t       tq[$];
   int  n_tlpb = 0, n_dllp = 0, n_sent = 0, n_split = 0, n_badfrm = 0;
   bit  in_tlp = 0;
   bit  abort_tx = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_ni) in_tlp = 0;
         else begin
            if (dllp_sent) n_sent++;
            if (m_tvalid && m_tready) begin
               if (m_tuser[0]) begin
                  n_dllp++;
                  if (in_tlp) n_split++;
                  if (m_tkeep != 4'hF || !m_tlast || m_tuser != 3'b001)
                     n_badfrm++;
                  if (m_tdata[7:0] inside {8'h80, 8'h90, 8'hA0})
                     fc_q.push_back(m_tdata);
                  else begin
                     ad_q.push_back(m_tdata);
                     ad_pos.push_back(n_tlpb);
                  end
               end else begin
                  tq.push_back('{m_tdata, m_tkeep, m_tlast, m_tuser});
                  n_tlpb++;
                  in_tlp = !m_tlast;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      ad_q.delete(); fc_q.delete(); ad_pos.delete(); tq.delete();
   endtask

   task automatic pulse_ack(input logic [11:0] seq, input logic nak);
      ack_req = 1'b1; ack_nak = nak; ack_seq = seq;
      cyc(1);
      ack_req = 1'b0; ack_nak = 1'b0;
   endtask

   task automatic relink();
      link = 1'b0;
      cyc(1);
      link = 1'b1;
   endtask

   task automatic send_tlp(input int n, input logic [31:0] base);
      int w;
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = base + 32'(i);
         s_tlast  = (i == n-1);
         s_tkeep  = (i == n-1) ? 4'h3 : 4'hF;
         s_tuser  = 3'b111;
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!s_tready && w < 200 && !abort_tx);
         if (abort_tx) break;
         if (w >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL tlp_timeout: got no tready expected handshake");
            break;
         end
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic chk_tlp(input string nm, input int n,
                          input logic [31:0] base);
      int bad = 0;
      beat_t b;
      check({nm, "_cnt"}, 32'(tq.size() >= n), 32'd1);
      for (int i = 0; i < n && tq.size() > 0; i++) begin
         b = tq.pop_front();
         if (b.d != base + 32'(i) || b.l != (i == n-1) ||
             b.k != ((i == n-1) ? 4'h3 : 4'hF) || b.u != 3'b110)
            bad++;
      end
      check({nm, "_beats"}, 32'(bad), 32'd0);
   endtask

   function automatic logic [31:0] pop_ad();
      if (ad_q.size() == 0) return 32'hDEAD_BEEF;
      return ad_q.pop_front();
   endfunction

   function automatic logic [31:0] pop_fc();
      if (fc_q.size() == 0) return 32'hDEAD_BEEF;
      return fc_q.pop_front();
   endfunction

   // kind: 0 Ack, 1 Nak, 2 UpdateFC-P, 3 UpdateFC-NP, 4 UpdateFC-Cpl
   typedef struct {
      int          kind;
      logic [11:0] seq;
      logic [7:0]  hdr;
      logic [11:0] dat;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[8];

   initial begin
      int bad, pos, t0, w;
      logic [31:0] got;

      vt[0] = '{0, 12'h123, 8'h00, 12'h000, 32'h2301_0000};
      vt[1] = '{0, 12'hABC, 8'h00, 12'h000, 32'hBC0A_0000};
      vt[2] = '{1, 12'h011, 8'h00, 12'h000, 32'h1100_0010};
      vt[3] = '{1, 12'hFFF, 8'h00, 12'h000, 32'hFF0F_0010};
      vt[4] = '{2, 12'h000, 8'h41, 12'h203, 32'h0342_1080};
      vt[5] = '{3, 12'h000, 8'hFF, 12'hFFF, 32'hFFCF_3F90};
      vt[6] = '{4, 12'h000, 8'h02, 12'h100, 32'h0081_00A0};
      vt[7] = '{2, 12'h000, 8'h00, 12'h000, 32'h0000_0080};

      rst_ni = 1'b0; link = 1'b0; m_tready = 1'b1;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0;
      s_tlast = 1'b0; s_tuser = '0;
      ack_req = 1'b0; ack_nak = 1'b0; ack_seq = '0; fc_req = '0;
      fc_ph = '0; fc_nph = '0; fc_cplh = '0;
      fc_pd = '0; fc_npd = '0; fc_cpld = '0;

      cyc(3);
      s_tvalid = 1'b1;
      #1;
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata", m_tdata, 32'd0);
      check("rst_tkeep", 32'(m_tkeep), 32'd0);
      check("rst_tlast", 32'(m_tlast), 32'd0);
      check("rst_tuser", 32'(m_tuser), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_ack_pend", 32'(ack_pend), 32'd0);
      check("rst_dllp_sent", 32'(dllp_sent), 32'd0);
      s_tvalid = 1'b0;
      cyc(1);
      rst_ni = 1'b1;
      cyc(2);

      foreach (vt[i]) begin
         clear_q();
         relink();
         fc_ph   = (vt[i].kind == 2) ? vt[i].hdr : ~vt[i].hdr;
         fc_nph  = (vt[i].kind == 3) ? vt[i].hdr : ~vt[i].hdr;
         fc_cplh = (vt[i].kind == 4) ? vt[i].hdr : ~vt[i].hdr;
         fc_pd   = (vt[i].kind == 2) ? vt[i].dat : ~vt[i].dat;
         fc_npd  = (vt[i].kind == 3) ? vt[i].dat : ~vt[i].dat;
         fc_cpld = (vt[i].kind == 4) ? vt[i].dat : ~vt[i].dat;
         if (vt[i].kind < 2)
            pulse_ack(vt[i].seq, vt[i].kind == 1);
         else begin
            fc_req = 3'b001 << (vt[i].kind - 2);
            cyc(1);
            fc_req = 3'b000;
         end
         cyc(20);
         check($sformatf("vec%0d_count", i),
               32'(ad_q.size() + fc_q.size()), 32'd1);
         got = (vt[i].kind < 2) ? pop_ad() : pop_fc();
         check($sformatf("vec%0d_tdata", i), got, vt[i].exp);
         check($sformatf("vec%0d_ack_pend", i), 32'(ack_pend), 32'd0);
      end

      clear_q();
      link = 1'b0;
      pulse_ack(12'h010, 1'b0);
      pulse_ack(12'h011, 1'b1);
      check("naksq_pend_held", 32'(ack_pend), 32'd1);
      link = 1'b1;
      cyc(20);
      check("naksq_count", 32'(ad_q.size()), 32'd1);
      check("naksq_tdata", pop_ad(), 32'h1100_0010);
      check("naksq_pend_clr", 32'(ack_pend), 32'd0);

      clear_q();
      relink();
      m_tready = 1'b0;
      pulse_ack(12'h3C5, 1'b0);
      cyc(2);
      fork
         send_tlp(2, 32'hB000_0000);
         begin
            bad = 0;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               if (m_tvalid !== 1'b1 || m_tdata !== 32'hC503_0000 ||
                   s_tready !== 1'b0)
                  bad++;
            end
            check("bp_hold", 32'(bad), 32'd0);
            @(posedge clk);
            #1;
            m_tready = 1'b1;
         end
      join
      cyc(10);
      check("bp_dllp_count", 32'(ad_q.size()), 32'd1);
      check("bp_dllp_tdata", pop_ad(), 32'hC503_0000);
      chk_tlp("bp_tlp", 2, 32'hB000_0000);

      clear_q();
      relink();
      t0 = n_tlpb;
      fork
         for (int p = 0; p < 4; p++)
            send_tlp(8, 32'h1000_0000 * (p + 1));
         begin
            cyc(3);
            pulse_ack(12'h005, 1'b0);
         end
      join
      cyc(10);
      check("urg_count", 32'(ad_q.size()), 32'd1);
      pos = (ad_pos.size() > 0) ? ad_pos[0] - t0 : -1;
      check("urg_tdata", pop_ad(), 32'h0500_0000);
      check("urg_boundary", 32'(pos % 8), 32'd0);
      check("urg_in_traffic", 32'(pos >= 8 && pos < 32), 32'd1);
      for (int p = 0; p < 4; p++)
         chk_tlp($sformatf("urg_tlp%0d", p), 8, 32'h1000_0000 * (p + 1));

      fc_ph = 8'h41; fc_pd = 12'h203;
      fc_nph = 8'h22; fc_npd = 12'h044;
      fc_cplh = 8'h08; fc_cpld = 12'h7FF;
      link = 1'b0;
      cyc(1);
      clear_q();
      link = 1'b1;
      cyc(60);
      check("fc_none_early", 32'(fc_q.size()), 32'd0);
      cyc(40);
      check("fc_first_burst", 32'(fc_q.size()), 32'd3);
      cyc(40);
      check("fc_second_burst", 32'(fc_q.size()), 32'd6);
      for (int r = 0; r < 2; r++) begin
         check($sformatf("fc%0d_p", r), pop_fc(), 32'h0342_1080);
         check($sformatf("fc%0d_np", r), pop_fc(), 32'h4480_0890);
         check($sformatf("fc%0d_cpl", r), pop_fc(), 32'hFF07_02A0);
      end
      link = 1'b0;
      cyc(80);
      check("fc_link_down", 32'(fc_q.size() + ad_q.size()), 32'd0);

      clear_q();
      pulse_ack(12'h777, 1'b0);
      check("rstmid_pend_set", 32'(ack_pend), 32'd1);
      t0 = n_tlpb;
      fork
         send_tlp(4, 32'hD000_0000);
         begin
            w = 0;
            while (n_tlpb < t0 + 2 && w < 50) begin
               @(negedge clk);
               w++;
            end
            check("rstmid_reached_beat2", 32'(n_tlpb >= t0 + 2), 32'd1);
            rst_ni = 1'b0;
            abort_tx = 1'b1;
            #1;
            check("rstmid_async_tvalid", 32'(m_tvalid), 32'd0);
         end
      join
      check("rstmid_s_tready", 32'(s_tready), 32'd0);
      cyc(3);
      rst_ni = 1'b1;
      abort_tx = 1'b0;
      cyc(2);
      check("rstmid_tvalid_after", 32'(m_tvalid), 32'd0);
      check("rstmid_pend_clr", 32'(ack_pend), 32'd0);
      clear_q();
      link = 1'b1;
      pulse_ack(12'h123, 1'b0);
      cyc(10);
      check("rstmid_after_count", 32'(ad_q.size()), 32'd1);
      check("rstmid_after_tdata", pop_ad(), 32'h2301_0000);
      check("rstmid_no_tlp_out", 32'(tq.size()), 32'd0);

      check("never_split_tlp", 32'(n_split), 32'd0);
      check("dllp_framing", 32'(n_badfrm), 32'd0);
      check("dllp_sent_pulses", 32'(n_sent), 32'(n_dllp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
